io_bus_ctrl: RTL

- Sequences the shared peripheral I/O bus.
- Arbitrates round-robin between NREQ requesters (CPU load/store unit, DMA).
- Decodes the address to a one-hot device enable (the per-peripheral EN grant) and drives the address and ctrl (read/write) lines.
- Inserts fixed wait states so registered peripheral outputs are valid before capture, then returns read data and a done pulse to the winning requester.

---
 rtl/io_bus_ctrl_pkg.sv | 26 ++
 rtl/io_bus_ctrl_if.sv | 41 ++++
 rtl/io_bus_ctrl_rr_arbiter.sv | 35 +++
 rtl/io_bus_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/io_bus_ctrl_pkg.sv
// io_bus_ctrl_pkg
//   Shared definitions for the peripheral I/O bus controller:
//   bus_ctrl line encoding, default geometry of the bus, and the
//   controller FSM state type.
package io_bus_ctrl_pkg;

  // Level driven on bus_ctrl
  localparam logic IO_CTRL_READ  = 1'b0;
  localparam logic IO_CTRL_WRITE = 1'b1;

  // Default bus geometry (CPU LSU + DMA, four mapped devices)
  localparam int IO_NREQ      = 2;
  localparam int IO_NDEV      = 4;
  localparam int IO_ADDR_W    = 16;
  localparam int IO_DATA_W    = 16;
  localparam int IO_DEV_SEL_W = 4;
  localparam int IO_WAIT      = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR
  } io_state_e;

endpackage

// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if
//   Bundles the requester handshake and the peripheral bus lines.
//   modport master : the controller (samples requests, drives the bus)
//   modport slave  : requesters and peripherals (the controller's environment)
//   Requester side : req, req_we, req_addr, req_wdata -> gnt, done, err, rdata
//   Peripheral side: dev_en, bus_addr, bus_ctrl, bus_wdata, bus_wdata_oe <- bus_rdata
interface io_bus_ctrl_if
  import io_bus_ctrl_pkg::*;
#(
  parameter int NREQ   = IO_NREQ,
  parameter int NDEV   = IO_NDEV,
  parameter int ADDR_W = IO_ADDR_W,
  parameter int DATA_W = IO_DATA_W
) ();

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic                   err;
  logic [DATA_W-1:0]      rdata;
  logic [NDEV-1:0]        dev_en;
  logic [ADDR_W-1:0]      bus_addr;
  logic                   bus_ctrl;
  logic [DATA_W-1:0]      bus_wdata;
  logic                   bus_wdata_oe;
  logic [DATA_W-1:0]      bus_rdata;

  modport master (
    input  req, req_we, req_addr, req_wdata, bus_rdata,
    output gnt, done, err, rdata, dev_en, bus_addr, bus_ctrl, bus_wdata, bus_wdata_oe
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, bus_rdata,
    input  gnt, done, err, rdata, dev_en, bus_addr, bus_ctrl, bus_wdata, bus_wdata_oe
  );

endinterface

// File: rtl/io_bus_ctrl_rr_arbiter.sv
// io_bus_ctrl_rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   ptr_i, wrapping. Holds no state; the owner keeps and advances the pointer.
//   req_i : request levels
//   ptr_i : highest-priority requester index
//   any_o : at least one request present
//   idx_o : winner index (0 when any_o is low)
//   gnt_o : winner one-hot (0 when any_o is low)
module io_bus_ctrl_rr_arbiter
  import io_bus_ctrl_pkg::*;
#(
  parameter int NREQ  = IO_NREQ,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [NREQ-1:0]  gnt_o
);

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_o && req_i[(int'(ptr_i) + i) % NREQ]) begin
        any_o = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + i) % NREQ);
        gnt_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl
//   Sequences the shared peripheral I/O bus: round-robin arbitration between
//   requesters, address decode to a one-hot device enable, WAIT extra cycles
//   of enable before read capture / write release, then a done pulse (plus err
//   for an unmapped device index). Every output is a register.
//   clk  : system clock
//   rst_n: asynchronous active-low reset
//   bus  : io_bus_ctrl_if.master (requester handshake + peripheral bus)
module io_bus_ctrl
  import io_bus_ctrl_pkg::*;
#(
  parameter int NREQ      = IO_NREQ,
  parameter int NDEV      = IO_NDEV,
  parameter int ADDR_W    = IO_ADDR_W,
  parameter int DATA_W    = IO_DATA_W,
  parameter int DEV_SEL_W = IO_DEV_SEL_W,
  parameter int WAIT      = IO_WAIT
) (
  input logic           clk,
  input logic           rst_n,
  io_bus_ctrl_if.master bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  io_state_e         state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d, win_q, win_d, rr_next;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, bus_wdata_q, bus_wdata_d;
  logic [NDEV-1:0]   dev_en_q, dev_en_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_ctrl_q, bus_ctrl_d, oe_q, oe_d;

  logic                 arb_any;
  logic [IDX_W-1:0]     arb_idx;
  logic [NREQ-1:0]      arb_gnt;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [DEV_SEL_W-1:0] sel_idx;
  logic                 sel_mapped;
  logic [NDEV-1:0]      sel_dev_en;

  io_bus_ctrl_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req_i (bus.req),
    .ptr_i (rr_q),
    .any_o (arb_any),
    .idx_o (arb_idx),
    .gnt_o (arb_gnt)
  );

  // Request fields of the current arbitration winner
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_idx    = sel_addr[ADDR_W-1 -: DEV_SEL_W];
  assign sel_mapped = (int'(sel_idx) < NDEV);

  always_comb begin
    sel_dev_en = '0;
    for (int d = 0; d < NDEV; d++) sel_dev_en[d] = (int'(sel_idx) == d);
  end

  assign rr_next = (int'(win_q) == NREQ - 1) ? '0 : win_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    wcnt_d      = wcnt_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    dev_en_d    = dev_en_q;
    bus_addr_d  = bus_addr_q;
    bus_ctrl_d  = bus_ctrl_q;
    bus_wdata_d = bus_wdata_q;
    oe_d        = oe_q;
    case (state_q)
      ST_IDLE: begin
        // After an ERR completion the done pulse is still visible in IDLE;
        // the finishing requester has not yet had a chance to drop req, so
        // arbitration waits one cycle rather than serve it a second time.
        if (arb_any && (done_q == '0)) begin
          win_d  = arb_idx;
          gnt_d  = arb_gnt;
          wcnt_d = '0;
          if (sel_mapped) begin
            state_d    = ST_ACCESS;
            dev_en_d   = sel_dev_en;
            bus_addr_d = sel_addr;
            bus_ctrl_d = sel_we ? IO_CTRL_WRITE : IO_CTRL_READ;
            oe_d       = sel_we;
            if (sel_we) bus_wdata_d = sel_wdata;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACCESS: begin
        if (wcnt_q == 4'(WAIT)) begin
          state_d  = ST_DONE;
          dev_en_d = '0;
          oe_d     = 1'b0;
          gnt_d    = '0;
          done_d   = gnt_q;
          rr_d     = rr_next;
          if (bus_ctrl_q == IO_CTRL_READ) rdata_d = bus.bus_rdata;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        done_d  = gnt_q;
        err_d   = 1'b1;
        rdata_d = '0;
        rr_d    = rr_next;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      win_q       <= '0;
      wcnt_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      dev_en_q    <= '0;
      bus_addr_q  <= '0;
      bus_ctrl_q  <= IO_CTRL_READ;
      bus_wdata_q <= '0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      wcnt_q      <= wcnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      dev_en_q    <= dev_en_d;
      bus_addr_q  <= bus_addr_d;
      bus_ctrl_q  <= bus_ctrl_d;
      bus_wdata_q <= bus_wdata_d;
      oe_q        <= oe_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.dev_en       = dev_en_q;
  assign bus.bus_addr     = bus_addr_q;
  assign bus.bus_ctrl     = bus_ctrl_q;
  assign bus.bus_wdata    = bus_wdata_q;
  assign bus.bus_wdata_oe = oe_q;

endmodule
